par_to_serial_tx: RTL

Transmit-side serializer that feeds the serial_to_parallel receiver. It accepts 8-bit bytes over a valid/ready handshake and shifts them out MSB-first, one bit per CLK cycle, on a single serial line. Whenever no byte is queued at a byte boundary it inserts the comma symbol (0xBC), so the receiver always sees a continuous, comma-aligned stream. An optional sync preamble of commas after reset gives the receiver time to lock before data flows.

---
 rtl/par_to_serial_tx.sv | 106 ++++++++++
 1 files changed

// File: rtl/par_to_serial_tx.sv
`default_nettype none
// ============================================================================
// Module   : par_to_serial_tx
// Purpose  : Byte-to-serial transmitter, MSB first, comma (COMMA) fill when idle.
//            Define PTS_SYNC_PREAMBLE_EN to send SYNC_WORDS commas after reset.
// Revision : 1.0
// ============================================================================
module par_to_serial_tx #(
  parameter logic [7:0] COMMA      = 8'hBC,
  parameter int         SYNC_WORDS = 4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] DATA_IN,
  input  logic       VALID_IN,
  output logic       READY_OUT,
  output logic       DATA_OUT,
  output logic       LOAD_OUT
);

  logic [7:0] hold_byte;
  logic       hold_full;
  logic [7:0] sr;
  logic [2:0] bcnt;
  logic       live;
  logic       accept;
  logic       load_edge;
  logic       take_hold;
  logic       is_active;
  logic [7:0] next_byte;

`ifdef PTS_SYNC_PREAMBLE_EN
  localparam logic [7:0] SYNC_LAST = SYNC_WORDS[7:0];

  typedef enum logic {
    ST_SYNC   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  state_t     state;
  logic [7:0] scnt;

  assign is_active = (state == ST_ACTIVE);
`else
  logic unused_sync_words;
  assign unused_sync_words = ^SYNC_WORDS[7:0];
  assign is_active         = 1'b1;
`endif

  assign accept    = VALID_IN && READY_OUT;
  assign load_edge = (bcnt == 3'd0);
  assign take_hold = load_edge && is_active && hold_full;
  assign next_byte = take_hold ? hold_byte : COMMA;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      hold_byte <= 8'd0;
      hold_full <= 1'b0;
      sr        <= 8'd0;
      bcnt      <= 3'd0;
      live      <= 1'b0;
      DATA_OUT  <= 1'b0;
      LOAD_OUT  <= 1'b0;
      READY_OUT <= 1'b0;
`ifdef PTS_SYNC_PREAMBLE_EN
      state     <= ST_SYNC;
      scnt      <= 8'd0;
`endif
    end else begin
      live <= 1'b1;
      bcnt <= bcnt + 3'd1;

      if (load_edge) begin
        DATA_OUT <= next_byte[7];
        sr       <= {next_byte[6:0], 1'b0};
        LOAD_OUT <= 1'b1;
      end else begin
        DATA_OUT <= sr[7];
        sr       <= {sr[6:0], 1'b0};
        LOAD_OUT <= 1'b0;
      end

      // An accept on a load edge only fills HOLD; the byte waits a full period.
      if (accept) begin
        hold_byte <= DATA_IN;
        hold_full <= 1'b1;
      end else if (take_hold) begin
        hold_full <= 1'b0;
      end

      // Uses pre-edge state so READY rises one edge after HOLD empties or ACTIVE begins.
      READY_OUT <= is_active && live && !hold_full && !accept;

`ifdef PTS_SYNC_PREAMBLE_EN
      if (state == ST_SYNC && load_edge) begin
        scnt <= scnt + 8'd1;
        if (scnt + 8'd1 == SYNC_LAST) begin
          state <= ST_ACTIVE;
        end
      end
`endif
    end
  end

endmodule
`default_nettype wire
